wishbone_stream_fifo: RTL and testbench

- Wishbone responder, one slave port on wishbone_interconnect; the fabric pushes 32-bit samples in, the CPU pops them over Wishbone.
- Counterpart to the scope write path: fabric is the producer, bus is the reader.
- Provides a control register, status with sticky error flags, a level-threshold IRQ and a pop-on-read data port.

---
 rtl/wishbone_stream_fifo_pkg.sv | 28 ++
 rtl/wishbone_stream_fifo_core.sv | 74 +++++++
 rtl/wishbone_stream_fifo.sv | 161 ++++++++++++++++
 tb/tb_wishbone_stream_fifo.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_stream_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_stream_fifo_pkg
// Brief    : Register map, control/status bit positions for the stream FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package wb_stream_fifo_pkg;

    // Word offsets (byte offset >> 2) of the register map
    localparam logic [5:0] REG_CTRL   = 6'h00;
    localparam logic [5:0] REG_STATUS = 6'h01;
    localparam logic [5:0] REG_DATA   = 6'h02;
    localparam logic [5:0] REG_THRESH = 6'h03;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FLUSH_BIT = 1;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_UNF_BIT   = 3;

    localparam int LEVEL_LSB   = 16;
    localparam int LEVEL_WIDTH = 8;
    localparam int THRESH_WIDTH = 8;

endpackage : wb_stream_fifo_pkg
`default_nettype wire

// File: rtl/wishbone_stream_fifo_core.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_core
// Brief    : Single-clock FIFO; head word visible combinationally on rd_data.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_core #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        flush,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(DEPTH):0]      level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL_LEVEL = DEPTH[c_PTR_W:0];

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W:0]      r_level;

    logic w_do_pop;
    logic w_do_push;

    assign empty   = (r_level == '0);
    assign full    = (r_level == c_FULL_LEVEL);
    assign level   = r_level;
    assign rd_data = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop) & ~flush;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + (c_PTR_W+1)'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_level <= r_level - (c_PTR_W+1)'(1);
            end
        end
    end

endmodule : sync_fifo_core
`default_nettype wire

// File: rtl/wishbone_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wishbone_stream_fifo
// Brief    : Wishbone responder draining a fabric-fed sample FIFO (pop on read).
// Revision : 1.0 - initial release
// ============================================================================
module wishbone_stream_fifo
    import wb_stream_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH     = 17,
    parameter int MUX_ADDR_WIDTH = 9,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 16
) (
    input  logic                                 WB_CLK,
    input  logic                                 WB_RST,
    input  logic                                 WBS_CYC,
    input  logic                                 WBS_STB,
    input  logic                                 WBS_WE,
    input  logic                                 WBS_RD,
    input  logic [3:0]                           WBS_BYTE_STB,
    input  logic [ADDR_WIDTH-MUX_ADDR_WIDTH-1:0] WBS_ADR,
    input  logic [DATA_WIDTH-1:0]                WBS_WR_DAT,
    output logic [DATA_WIDTH-1:0]                WBS_RD_DAT,
    output logic                                 WBS_ACK,
    input  logic [DATA_WIDTH-1:0]                IN_DATA,
    input  logic                                 IN_VALID,
    output logic                                 IRQ
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic                    r_ack;
    logic [DATA_WIDTH-1:0]   r_rd_dat;
    logic                    r_en;
    logic                    r_ovf;
    logic                    r_unf;
    logic                    r_irq;
    logic [THRESH_WIDTH-1:0] r_thresh;

    logic                    w_req;
    logic                    w_rd;
    logic                    w_wr;
    logic [5:0]              w_reg_sel;
    logic                    w_wr_ctrl;
    logic                    w_wr_status;
    logic                    w_wr_thresh;
    logic                    w_rd_data;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_flush;
    logic                    w_ovf_set;
    logic                    w_unf_set;
    logic                    w_empty;
    logic                    w_full;
    logic [c_PTR_W:0]        w_level;
    logic [LEVEL_WIDTH-1:0]  w_level8;
    logic [DATA_WIDTH-1:0]   w_head;
    logic [DATA_WIDTH-1:0]   w_status;
    logic [DATA_WIDTH-1:0]   w_rd_mux;
    logic                    w_unused;

    assign w_unused = ^{WBS_RD, WBS_BYTE_STB[3:1], WBS_ADR[1:0], WBS_WR_DAT[DATA_WIDTH-1:8]};

    // Holding ACK off the request term gives exactly one ACK per held strobe
    assign w_req     = WBS_CYC & WBS_STB & ~r_ack;
    assign w_rd      = w_req & ~WBS_WE;
    assign w_wr      = w_req & WBS_WE;
    assign w_reg_sel = WBS_ADR[7:2];

    assign w_wr_ctrl   = w_wr & WBS_BYTE_STB[0] & (w_reg_sel == REG_CTRL);
    assign w_wr_status = w_wr & WBS_BYTE_STB[0] & (w_reg_sel == REG_STATUS);
    assign w_wr_thresh = w_wr & WBS_BYTE_STB[0] & (w_reg_sel == REG_THRESH);
    assign w_rd_data   = w_rd & (w_reg_sel == REG_DATA);

    assign w_pop     = w_rd_data & ~w_empty;
    assign w_unf_set = w_rd_data & w_empty;
    assign w_flush   = w_wr_ctrl & WBS_WR_DAT[CTRL_FLUSH_BIT];
    assign w_push    = IN_VALID & r_en;
    assign w_ovf_set = w_push & w_full & ~w_pop & ~w_flush;

    assign w_level8 = LEVEL_WIDTH'(w_level);

    sync_fifo_core #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk     (WB_CLK),
        .rst_n   (WB_RST),
        .push    (w_push),
        .pop     (w_pop),
        .flush   (w_flush),
        .wr_data (IN_DATA),
        .rd_data (w_head),
        .empty   (w_empty),
        .full    (w_full),
        .level   (w_level)
    );

    always_comb begin
        w_status                              = '0;
        w_status[STAT_EMPTY_BIT]              = w_empty;
        w_status[STAT_FULL_BIT]               = w_full;
        w_status[STAT_OVF_BIT]                = r_ovf;
        w_status[STAT_UNF_BIT]                = r_unf;
        w_status[LEVEL_LSB +: LEVEL_WIDTH]    = w_level8;
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_reg_sel)
            REG_CTRL:   w_rd_mux[CTRL_EN_BIT] = r_en;
            REG_STATUS: w_rd_mux = w_status;
            REG_DATA:   w_rd_mux = w_empty ? '0 : w_head;
            REG_THRESH: w_rd_mux[THRESH_WIDTH-1:0] = r_thresh;
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge WB_CLK or negedge WB_RST) begin
        if (!WB_RST) begin
            r_ack    <= 1'b0;
            r_rd_dat <= '0;
            r_en     <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_irq    <= 1'b0;
            r_thresh <= '0;
        end else begin
            r_ack    <= w_req;
            r_rd_dat <= w_rd ? w_rd_mux : '0;

            if (w_wr_ctrl) begin
                r_en <= WBS_WR_DAT[CTRL_EN_BIT];
            end
            if (w_wr_thresh) begin
                r_thresh <= WBS_WR_DAT[THRESH_WIDTH-1:0];
            end

            // A new event wins over a same-cycle write-1-to-clear
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status && WBS_WR_DAT[STAT_OVF_BIT]) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end else if (w_wr_status && WBS_WR_DAT[STAT_UNF_BIT]) begin
                r_unf <= 1'b0;
            end

            r_irq <= ((r_thresh != '0) && (w_level8 >= r_thresh)) || r_ovf;
        end
    end

    assign WBS_ACK    = r_ack;
    assign WBS_RD_DAT = r_rd_dat;
    assign IRQ        = r_irq;

endmodule : wishbone_stream_fifo
`default_nettype wire

// File: tb/tb_wishbone_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_wishbone_stream_fifo
// Brief    : Directed + random bench against a queue-based model of the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wishbone_stream_fifo;

    localparam int DEPTH = 16;

    logic        WB_CLK = 1'b0;
    logic        WB_RST = 1'b0;
    logic        WBS_CYC = 1'b0;
    logic        WBS_STB = 1'b0;
    logic        WBS_WE = 1'b0;
    logic        WBS_RD = 1'b0;
    logic [3:0]  WBS_BYTE_STB = 4'h0;
    logic [7:0]  WBS_ADR = 8'h00;
    logic [31:0] WBS_WR_DAT = 32'h0;
    logic [31:0] WBS_RD_DAT;
    logic        WBS_ACK;
    logic [31:0] IN_DATA = 32'h0;
    logic        IN_VALID = 1'b0;
    logic        IRQ;

    wishbone_stream_fifo #(
        .ADDR_WIDTH     (17),
        .MUX_ADDR_WIDTH (9),
        .DATA_WIDTH     (32),
        .DEPTH          (DEPTH)
    ) dut (
        .WB_CLK       (WB_CLK),
        .WB_RST       (WB_RST),
        .WBS_CYC      (WBS_CYC),
        .WBS_STB      (WBS_STB),
        .WBS_WE       (WBS_WE),
        .WBS_RD       (WBS_RD),
        .WBS_BYTE_STB (WBS_BYTE_STB),
        .WBS_ADR      (WBS_ADR),
        .WBS_WR_DAT   (WBS_WR_DAT),
        .WBS_RD_DAT   (WBS_RD_DAT),
        .WBS_ACK      (WBS_ACK),
        .IN_DATA      (IN_DATA),
        .IN_VALID     (IN_VALID),
        .IRQ          (IRQ)
    );

    always #5 WB_CLK = ~WB_CLK;

    // Reference model: sample queue plus register/flag state
    logic [31:0] q[$];
    logic        m_en, m_ovf, m_unf, m_ack, m_irq;
    logic [7:0]  m_thresh;
    logic [31:0] m_rdat;
    int          total = 0;
    int          bad = 0;
    int          step = 0;

    task automatic model_reset();
        q.delete();
        m_en = 0; m_ovf = 0; m_unf = 0; m_ack = 0; m_irq = 0;
        m_thresh = 8'd0; m_rdat = 32'd0;
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'd0;
        s[0] = (q.size() == 0);
        s[1] = (q.size() == DEPTH);
        s[2] = m_ovf;
        s[3] = m_unf;
        s[23:16] = 8'(q.size());
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, step, obs, exp);
        end
    endtask

    // One clock: drive bus/fabric inputs, advance the model, compare after the edge
    task automatic cyc_step(input logic c, input logic we, input logic [7:0] adr,
                            input logic [31:0] wd, input logic [3:0] be,
                            input logic iv, input logic [31:0] id);
        logic req, popped, flush, accept, ovf_set, unf_set, irq_n, wr_ok;
        logic [31:0] rdat;
        WBS_CYC = c; WBS_STB = c; WBS_WE = we; WBS_ADR = adr;
        WBS_WR_DAT = wd; WBS_BYTE_STB = be; IN_VALID = iv; IN_DATA = id;
        req = c && !m_ack;
        wr_ok = req && we && be[0];
        rdat = 32'd0; popped = 0; flush = 0; accept = 0; ovf_set = 0; unf_set = 0;
        irq_n = ((m_thresh != 0) && (q.size() >= int'(m_thresh))) || m_ovf;
        if (req && !we) begin
            case (adr[7:2])
                6'd0: rdat = {31'd0, m_en};
                6'd1: rdat = m_status();
                6'd2: if (q.size() > 0) begin rdat = q[0]; popped = 1; end else unf_set = 1;
                6'd3: rdat = {24'd0, m_thresh};
                default: rdat = 32'd0;
            endcase
        end
        if (wr_ok && adr[7:2] == 6'd0) flush = wd[1];
        if (iv && m_en && !flush) begin
            if (q.size() < DEPTH || popped) accept = 1;
            else ovf_set = 1;
        end
        if (popped) void'(q.pop_front());
        if (accept) q.push_back(id);
        if (flush) q.delete();
        if (wr_ok) begin
            case (adr[7:2])
                6'd0: m_en = wd[0];
                6'd1: begin if (wd[2]) m_ovf = 0; if (wd[3]) m_unf = 0; end
                6'd3: m_thresh = wd[7:0];
                default: ;
            endcase
        end
        if (ovf_set) m_ovf = 1;
        if (unf_set) m_unf = 1;
        m_ack = req; m_rdat = rdat; m_irq = irq_n;
        @(posedge WB_CLK);
        #1;
        step++;
        chk("ack", {31'd0, WBS_ACK}, {31'd0, m_ack});
        chk("rd_dat", WBS_RD_DAT, m_rdat);
        chk("irq", {31'd0, IRQ}, {31'd0, m_irq});
    endtask

    task automatic idle(input logic iv, input logic [31:0] id);
        cyc_step(1'b0, 1'b0, 8'h00, 32'd0, 4'h0, iv, id);
    endtask

    task automatic bus_wr(input logic [7:0] adr, input logic [31:0] wd, input logic [3:0] be);
        cyc_step(1'b1, 1'b1, adr, wd, be, 1'b0, 32'd0);
        idle(1'b0, 32'd0);
    endtask

    task automatic bus_rd(input logic [7:0] adr, input logic iv, input logic [31:0] id);
        cyc_step(1'b1, 1'b0, adr, 32'd0, 4'hF, iv, id);
        idle(1'b0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  adr;
        logic [31:0] wd;
        logic        c, we, iv;
        logic [3:0]  be;

        model_reset();
        #1;
        chk("reset_ack", {31'd0, WBS_ACK}, 32'd0);
        chk("reset_rd_dat", WBS_RD_DAT, 32'd0);
        chk("reset_irq", {31'd0, IRQ}, 32'd0);
        repeat (3) @(posedge WB_CLK);
        @(negedge WB_CLK);
        WB_RST = 1'b1;
        @(posedge WB_CLK);
        #1;

        // Status after reset, then a held strobe that must not double-ACK
        bus_rd(8'h04, 1'b0, 32'd0);
        cyc_step(1'b1, 1'b0, 8'h04, 32'd0, 4'hF, 1'b0, 32'd0);
        cyc_step(1'b1, 1'b0, 8'h04, 32'd0, 4'hF, 1'b0, 32'd0);
        idle(1'b0, 32'd0);
        idle(1'b0, 32'd0);

        // Basic ordering
        bus_wr(8'h00, 32'h1, 4'hF);
        for (int i = 0; i < 3; i++) idle(1'b1, 32'hA0 + i);
        for (int i = 0; i < 3; i++) bus_rd(8'h08, 1'b0, 32'd0);
        bus_rd(8'h04, 1'b0, 32'd0);

        // Overflow at DEPTH+1 pushes, then write-1-to-clear OVF
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1, 32'hB0 + i);
        bus_rd(8'h04, 1'b0, 32'd0);
        bus_wr(8'h04, 32'h4, 4'h1);
        idle(1'b0, 32'd0);
        bus_rd(8'h04, 1'b0, 32'd0);

        // Full FIFO: pop and push in the same commit edge
        bus_rd(8'h08, 1'b1, 32'hCC);
        bus_rd(8'h04, 1'b0, 32'd0);

        // Byte lane 0 disabled: THRESH write ignored
        bus_wr(8'h0C, 32'h5, 4'hE);
        bus_rd(8'h0C, 1'b0, 32'd0);

        // Threshold IRQ and underflow
        bus_wr(8'h00, 32'h3, 4'hF);
        bus_wr(8'h0C, 32'h4, 4'h1);
        for (int i = 0; i < 3; i++) idle(1'b1, 32'hC0 + i);
        idle(1'b0, 32'd0);
        idle(1'b0, 32'd0);
        idle(1'b1, 32'hC3);
        idle(1'b0, 32'd0);
        idle(1'b0, 32'd0);
        for (int i = 0; i < 4; i++) bus_rd(8'h08, 1'b0, 32'd0);
        bus_rd(8'h08, 1'b0, 32'd0);
        bus_rd(8'h04, 1'b0, 32'd0);
        bus_wr(8'h04, 32'h8, 4'h1);
        bus_rd(8'h04, 1'b0, 32'd0);

        // Flush with a coincident push; CTRL keeps EN and reads FLUSH as 0
        for (int i = 0; i < 5; i++) idle(1'b1, 32'hD0 + i);
        cyc_step(1'b1, 1'b1, 8'h00, 32'h3, 4'hF, 1'b1, 32'hDD);
        idle(1'b0, 32'd0);
        bus_rd(8'h04, 1'b0, 32'd0);
        bus_rd(8'h00, 1'b0, 32'd0);

        // EN=0: pushes ignored, stored data still poppable, unmapped offset
        idle(1'b1, 32'hE0);
        idle(1'b1, 32'hE1);
        bus_wr(8'h00, 32'h0, 4'hF);
        idle(1'b1, 32'hE2);
        bus_rd(8'h04, 1'b0, 32'd0);
        bus_rd(8'h08, 1'b0, 32'd0);
        bus_wr(8'h10, 32'hFFFF_FFFF, 4'hF);
        bus_rd(8'h10, 1'b0, 32'd0);

        // Randomized traffic
        bus_wr(8'h00, 32'h1, 4'hF);
        for (int n = 0; n < 600; n++) begin
            c  = ($urandom_range(0, 2) != 0);
            we = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 6))
                0: adr = 8'h00;
                1: adr = 8'h04;
                2, 3: adr = 8'h08;
                4: adr = 8'h0C;
                5: adr = 8'h14;
                default: adr = 8'h08;
            endcase
            wd = $urandom();
            be = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) be[0] = 1'b1;
            iv = ($urandom_range(0, 1) == 1);
            if (adr == 8'h00) begin
                wd[0] = ($urandom_range(0, 3) != 0);
                wd[1] = ($urandom_range(0, 7) == 0);
            end
            if (adr == 8'h0C) wd[7:0] = 8'($urandom_range(0, DEPTH + 1));
            if (adr == 8'h04 && iv && m_en && q.size() >= DEPTH) wd[2] = 1'b0;
            cyc_step(c, we, adr, wd, be, iv, $urandom());
        end
        idle(1'b0, 32'd0);
        idle(1'b0, 32'd0);

        // Asynchronous reset while a transfer is being acknowledged
        WBS_CYC = 1'b1; WBS_STB = 1'b1; WBS_WE = 1'b0; WBS_ADR = 8'h04; IN_VALID = 1'b0;
        @(posedge WB_CLK);
        #1;
        chk("midrst_ack_before", {31'd0, WBS_ACK}, 32'd1);
        #2;
        WB_RST = 1'b0;
        #1;
        chk("midrst_ack", {31'd0, WBS_ACK}, 32'd0);
        chk("midrst_rd_dat", WBS_RD_DAT, 32'd0);
        chk("midrst_irq", {31'd0, IRQ}, 32'd0);
        WBS_CYC = 1'b0; WBS_STB = 1'b0;
        model_reset();
        repeat (2) @(posedge WB_CLK);
        @(negedge WB_CLK);
        WB_RST = 1'b1;
        @(posedge WB_CLK);
        #1;
        bus_rd(8'h04, 1'b0, 32'd0);
        bus_rd(8'h00, 1'b0, 32'd0);
        bus_rd(8'h0C, 1'b0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wishbone_stream_fifo
`default_nettype wire
